// File: rtl/position_stack.sv
// Handshaked LIFO holding queen positions for the 8-queen solver.
// Push and pop each take two cycles; an indexed port reads entries without popping them.
module position_stack #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 8,
   parameter int PTR_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] data_out,
   output logic             stack_ready,
   output logic             underflow,
   output logic             overflow,
   output logic             empty,
   output logic             full,
   output logic [PTR_W-1:0] count,
   input  logic [PTR_W-2:0] rd_index,
   output logic [WIDTH-1:0] rd_data
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] PUSH_WR = 2'd1;
   localparam logic [1:0] POP_RD  = 2'd2;

   localparam logic [PTR_W-1:0] SP_ONE  = 1;
   localparam logic [PTR_W-2:0] IDX_ONE = 1;
   localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);

   logic [1:0]       state;
   logic [PTR_W-1:0] sp;
   logic [WIDTH-1:0] hold;
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-2:0] wr_idx;
   logic [PTR_W-2:0] top_idx;

   // sp never exceeds DEPTH, and in PUSH_WR it is below DEPTH, so the low bits index the array.
   assign wr_idx      = sp[PTR_W-2:0];
   assign top_idx     = wr_idx - IDX_ONE;
   assign stack_ready = (state == IDLE);
   assign empty       = (sp == '0);
   assign full        = (sp == SP_FULL);
   assign count       = sp;
   assign rd_data     = mem[rd_index];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         sp        <= '0;
         data_out  <= '0;
         underflow <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         underflow <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  sp       <= '0;
                  overflow <= 1'b0;
               end else if (push) begin
                  // A simultaneous pop is dropped here whether or not the push succeeds.
                  if (!full) state    <= PUSH_WR;
                  else       overflow <= 1'b1;
               end else if (pop) begin
                  if (!empty) state     <= POP_RD;
                  else        underflow <= 1'b1;
               end
            end
            PUSH_WR: begin
               sp    <= sp + SP_ONE;
               state <= IDLE;
            end
            POP_RD: begin
               data_out <= mem[top_idx];
               sp       <= sp - SP_ONE;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage and the push holding register carry data only and are never reset.
   always_ff @(posedge clk) begin
      if (state == IDLE && !clear && push && !full)
         hold <= data_in;
      if (state == PUSH_WR)
         mem[wr_idx] <= hold;
   end

endmodule

// File: tb/tb_position_stack.sv
// Self-checking bench for position_stack: a reference stack model feeds a queue
// of expected pop results that is drained as the DUT completes each pop.
module tb_position_stack;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       clear;
   logic       push;
   logic       pop;
   logic [5:0] data_in;
   logic [5:0] data_out;
   logic       stack_ready;
   logic       underflow;
   logic       overflow;
   logic       empty;
   logic       full;
   logic [3:0] count;
   logic [2:0] rd_index;
   logic [5:0] rd_data;

   int n_chk  = 0;
   int n_pass = 0;
   int uf_cnt = 0;

   logic [5:0] model [$];
   logic [5:0] exp_q [$];

   position_stack #(.WIDTH(6), .DEPTH(8), .PTR_W(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .clear      (clear),
      .push       (push),
      .pop        (pop),
      .data_in    (data_in),
      .data_out   (data_out),
      .stack_ready(stack_ready),
      .underflow  (underflow),
      .overflow   (overflow),
      .empty      (empty),
      .full       (full),
      .count      (count),
      .rd_index   (rd_index),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (underflow === 1'b1) uf_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic chk_rd(input logic [2:0] idx, input logic [5:0] exp);
      rd_index = idx;
      #1;
      chk("rd_data", 32'(rd_data), 32'(exp));
   endtask

   // Issue one request and follow it to completion; pops queue their expected result.
   task automatic req(input bit p, input bit q, input logic [5:0] d);
      bit busy;
      bit is_pop;
      busy   = 1'b0;
      is_pop = 1'b0;
      if (p && model.size() < 8) begin
         model.push_back(d);
         busy = 1'b1;
      end else if (!p && q && model.size() > 0) begin
         exp_q.push_back(model.pop_back());
         busy   = 1'b1;
         is_pop = 1'b1;
      end
      @(negedge clk);
      push = p; pop = q; data_in = d;
      @(negedge clk);
      push = 1'b0; pop = 1'b0;
      chk("ready_after_req", 32'(stack_ready), busy ? 32'd0 : 32'd1);
      if (busy) begin
         @(negedge clk);
         chk("ready_done", 32'(stack_ready), 32'd1);
      end
      if (is_pop) chk("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      chk("count", 32'(count), 32'(model.size()));
   endtask

   initial begin
      int base;
      reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
      data_in = '0; rd_index = '0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(stack_ready), 32'd1);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_data_out", 32'(data_out), 32'd0);
      chk("rst_flags", {30'd0, underflow, overflow}, 32'd0);
      reset_n = 1'b1;

      // single push
      req(1'b1, 1'b0, 6'o12);
      chk("empty_after_push", 32'(empty), 32'd0);
      chk_rd(3'd0, 6'o12);
      req(1'b0, 1'b1, 6'o00);

      // fill and drain in LIFO order
      base = uf_cnt;
      for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 6'(i));
      chk("full_after_8", 32'(full), 32'd1);
      for (int i = 0; i < 8; i++) req(1'b0, 1'b1, 6'o00);
      chk("empty_after_8", 32'(empty), 32'd1);
      chk("no_underflow", 32'(uf_cnt - base), 32'd0);

      // overflow on full stack, then clear
      for (int i = 0; i < 8; i++) req(1'b1, 1'b0, 6'(i + 8));
      req(1'b1, 1'b0, 6'o55);
      chk("overflow_set", 32'(overflow), 32'd1);
      chk_rd(3'd7, 6'o17);
      repeat (3) @(negedge clk);
      chk("overflow_sticky", 32'(overflow), 32'd1);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      model.delete();
      chk("clear_count", 32'(count), 32'd0);
      chk("clear_overflow", 32'(overflow), 32'd0);
      chk("clear_empty", 32'(empty), 32'd1);

      // pop on empty
      req(1'b1, 1'b0, 6'o44);
      req(1'b0, 1'b1, 6'o00);
      req(1'b0, 1'b1, 6'o00);
      chk("underflow_pulse", 32'(underflow), 32'd1);
      @(negedge clk);
      chk("underflow_clears", 32'(underflow), 32'd0);
      chk("data_out_kept", 32'(data_out), 32'(6'o44));
      chk("ready_on_underflow", 32'(stack_ready), 32'd1);

      // simultaneous push and pop: push wins
      req(1'b1, 1'b0, 6'o01);
      req(1'b1, 1'b0, 6'o02);
      req(1'b1, 1'b0, 6'o03);
      req(1'b1, 1'b1, 6'o21);
      chk_rd(3'd3, 6'o21);
      chk_rd(3'd2, 6'o03);
      repeat (2) @(negedge clk);
      chk("pop_dropped", 32'(count), 32'd4);

      // reset in PUSH_WR aborts immediately
      @(negedge clk);
      push = 1'b1; data_in = 6'o15;
      @(negedge clk);
      push = 1'b0;
      chk("busy_before_rst", 32'(stack_ready), 32'd0);
      reset_n = 1'b0;
      #1;
      chk("async_rst_count", 32'(count), 32'd0);
      chk("async_rst_ready", 32'(stack_ready), 32'd1);
      chk("async_rst_data_out", 32'(data_out), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      model.delete();

      // push while busy is ignored
      @(negedge clk);
      push = 1'b1; data_in = 6'o26;
      @(negedge clk);
      chk("busy_push", 32'(stack_ready), 32'd0);
      data_in = 6'o33;
      @(negedge clk);
      push = 1'b0;
      chk("busy_done", 32'(stack_ready), 32'd1);
      chk("busy_count", 32'(count), 32'd1);
      repeat (2) @(negedge clk);
      chk("busy_ignored", 32'(count), 32'd1);
      chk_rd(3'd0, 6'o26);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
